// File: rtl/mcif_rd_arb_4r.sv
// Round-robin AXI read arbiter for four feature-read clients: tags ARID with the
// client index, counts outstanding bursts per client and routes R beats by RID.
module mcif_rd_arb_4r #(
  parameter int M_AXI_ID_WIDTH   = 4,
  parameter int M_AXI_DATA_WIDTH = 64,
  parameter int LEN_W            = 4,
  parameter int MAX_OUTS         = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    rd_req_vld,
  output logic [3:0]                    rd_req_rdy,
  input  logic [4*(LEN_W+64)-1:0]       rd_req_pd,
  output logic [3:0]                    rd_resp_vld,
  input  logic [3:0]                    rd_resp_rdy,
  output logic [M_AXI_DATA_WIDTH-1:0]   rd_resp_pd,
  output logic [3:0]                    rd_resp_last,
  output logic                          rd_err,
  output logic [M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [31:0]                   M_AXI_ARADDR,
  output logic [LEN_W-1:0]              M_AXI_ARLEN,
  output logic                          M_AXI_ARVALID,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARLOCK,
  output logic [3:0]                    M_AXI_ARCACHE,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic [3:0]                    M_AXI_ARQOS,
  input  logic                          M_AXI_ARREADY,
  input  logic [M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int PDW = LEN_W + 64;
  localparam int CW  = $clog2(MAX_OUTS) + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t          state, state_nxt;
  logic [1:0]      ptr;
  logic [CW-1:0]   outs [4];
  logic [3:0]      elig;
  logic            gnt_vld;
  logic [1:0]      gnt;
  logic            take;
  logic            rid_ok;
  logic [1:0]      rid_k;
  logic            done;
  logic            dec_ok;
  logic            unused_ok;

  assign M_AXI_ARSIZE  = 3'($clog2(M_AXI_DATA_WIDTH / 8));
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'b0010;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b0000;
  assign M_AXI_ARVALID = (state == ISSUE);
  assign unused_ok     = ^{M_AXI_RRESP, rd_req_pd};

  always_comb begin
    for (int i = 0; i < 4; i++)
      elig[i] = rd_req_vld[i] && (outs[i] < CW'(MAX_OUTS));
  end

  // Scan from the far end so the lowest offset from ptr wins.
  always_comb begin
    logic [1:0] idx;
    gnt_vld = 1'b0;
    gnt     = ptr;
    for (int n = 3; n >= 0; n--) begin
      idx = ptr + 2'(n);
      if (elig[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    rd_req_rdy = 4'b0000;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_vld) begin
          rd_req_rdy[gnt] = 1'b1;
          take            = 1'b1;
          state_nxt       = ISSUE;
        end
      end
      ISSUE: begin
        if (M_AXI_ARREADY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= 2'd0;
      M_AXI_ARID   <= '0;
      M_AXI_ARADDR <= '0;
      M_AXI_ARLEN  <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        ptr          <= gnt + 2'd1;
        M_AXI_ARID   <= M_AXI_ID_WIDTH'(gnt);
        M_AXI_ARADDR <= rd_req_pd[gnt*PDW +: 32];
        M_AXI_ARLEN  <= rd_req_pd[gnt*PDW+64 +: LEN_W];
      end
    end
  end

  // Unknown RIDs are drained with RREADY high and reach no client.
  assign rid_ok = ((M_AXI_RID >> 2) == '0);
  assign rid_k  = M_AXI_RID[1:0];

  always_comb begin
    rd_resp_vld  = 4'b0000;
    rd_resp_last = 4'b0000;
    M_AXI_RREADY = 1'b1;
    if (rid_ok) begin
      rd_resp_vld[rid_k]  = M_AXI_RVALID;
      rd_resp_last[rid_k] = M_AXI_RLAST;
      M_AXI_RREADY        = rd_resp_rdy[rid_k];
    end
  end

  assign rd_resp_pd = M_AXI_RDATA;
  assign done       = M_AXI_RVALID && M_AXI_RREADY && M_AXI_RLAST && rid_ok;
  assign dec_ok     = done && (outs[rid_k] != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) outs[i] <= '0;
      rd_err <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if ((take && gnt == 2'(i)) && !(dec_ok && rid_k == 2'(i)))
          outs[i] <= outs[i] + CW'(1);
        else if (!(take && gnt == 2'(i)) && (dec_ok && rid_k == 2'(i)))
          outs[i] <= outs[i] - CW'(1);
      end
      if ((M_AXI_RVALID && !rid_ok) || (done && !dec_ok))
        rd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mcif_rd_arb_4r.sv
// Randomized self-checking bench for mcif_rd_arb_4r against a behavioural
// model of grants, outstanding-burst counts and R routing.
module tb_mcif_rd_arb_4r;
  localparam int IDW = 4;
  localparam int DW  = 64;
  localparam int LW  = 4;
  localparam int PDW = LW + 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        vld;
  logic [3:0]        rdy;
  logic [4*PDW-1:0]  pd;
  logic [3:0]        resp_vld;
  logic [3:0]        resp_rdy;
  logic [DW-1:0]     resp_pd;
  logic [3:0]        resp_last;
  logic              rd_err;
  logic [IDW-1:0]    arid;
  logic [31:0]       araddr;
  logic [LW-1:0]     arlen;
  logic              arvalid;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic              arready;
  logic [IDW-1:0]    rid;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  int total = 0;
  int bad   = 0;

  // behavioural model
  bit          m_issue;
  int          m_ptr;
  int          m_outs [4];
  int          m_arid;
  logic [31:0] m_araddr;
  logic [LW-1:0] m_arlen;
  bit          m_err;
  int          exp_g;
  logic [3:0]  exp_rdy, exp_rvld, exp_rlast;
  logic        exp_rready;

  mcif_rd_arb_4r #(.M_AXI_ID_WIDTH(IDW), .M_AXI_DATA_WIDTH(DW), .LEN_W(LW), .MAX_OUTS(4)) dut (
    .clk(clk), .rst(rst),
    .rd_req_vld(vld), .rd_req_rdy(rdy), .rd_req_pd(pd),
    .rd_resp_vld(resp_vld), .rd_resp_rdy(resp_rdy), .rd_resp_pd(resp_pd),
    .rd_resp_last(resp_last), .rd_err(rd_err),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock),
    .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos),
    .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_issue = 0; m_ptr = 0; m_arid = 0; m_araddr = '0; m_arlen = '0; m_err = 0;
    for (int i = 0; i < 4; i++) m_outs[i] = 0;
  endtask

  task automatic model_eval();
    exp_g = -1; exp_rdy = '0; exp_rvld = '0; exp_rlast = '0; exp_rready = 1'b1;
    if (!m_issue) begin
      for (int n = 0; n < 4; n++) begin
        int c;
        c = (m_ptr + n) % 4;
        if (exp_g < 0 && vld[c] && m_outs[c] < 4) exp_g = c;
      end
      if (exp_g >= 0) exp_rdy[exp_g] = 1'b1;
    end
    if (int'(rid) < 4) begin
      exp_rvld[rid[1:0]]  = rvalid;
      exp_rlast[rid[1:0]] = rlast;
      exp_rready          = resp_rdy[rid[1:0]];
    end
  endtask

  task automatic model_commit();
    bit dec, zero_dec;
    int k;
    k = int'(rid);
    dec = 0; zero_dec = 0;
    if (rvalid && exp_rready && rlast && k < 4) begin
      if (m_outs[k] == 0) zero_dec = 1; else dec = 1;
    end
    if (rvalid && k >= 4) m_err = 1;
    if (zero_dec) m_err = 1;
    if (dec) m_outs[k]--;
    if (m_issue) begin
      if (arready) m_issue = 0;
    end else if (exp_g >= 0) begin
      m_arid   = exp_g;
      m_araddr = pd[exp_g*PDW +: 32];
      m_arlen  = pd[exp_g*PDW+64 +: LW];
      m_ptr    = (exp_g + 1) % 4;
      m_outs[exp_g]++;
      m_issue  = 1;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic rand_pd();
    for (int c = 0; c < 4; c++) begin
      pd[c*PDW +: 32]      = $urandom;
      pd[c*PDW+32 +: 32]   = $urandom;
      pd[c*PDW+64 +: LW]   = LW'($urandom_range(0, 15));
    end
  endtask

  task automatic idle_inputs();
    vld = '0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rid = '0;
    rdata = '0; rresp = '0; resp_rdy = 4'hF;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs(); rand_pd();
    do_reset();
    #1;
    total++;
    if (rdy !== 4'b0 || arvalid !== 1'b0 || arid !== '0 || araddr !== '0 || arlen !== '0 || rd_err !== 1'b0) begin
      bad++;
      $display("FAIL reset: rdy=%b arvalid=%b arid=%0d araddr=%h arlen=%0d err=%b, required all zero",
               rdy, arvalid, arid, araddr, arlen, rd_err);
    end
    total++;
    if (arsize !== 3'd3 || arburst !== 2'b01 || arlock !== 1'b0 || arcache !== 4'b0010 || arprot !== 3'd0 || arqos !== 4'd0) begin
      bad++;
      $display("FAIL ar_const: size=%0d burst=%b lock=%b cache=%b prot=%0d qos=%0d, required 3/01/0/0010/0/0",
               arsize, arburst, arlock, arcache, arprot, arqos);
    end
  endtask

  task automatic test_round_robin();
    int ids[$];
    int grants;
    idle_inputs(); do_reset(); rand_pd();
    vld = 4'hF; arready = 1'b1; grants = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1; model_eval();
      total++;
      if (rdy !== exp_rdy || arvalid !== m_issue) begin
        bad++;
        $display("FAIL rr_grant c%0d: rdy=%b arvalid=%b, required rdy=%b arvalid=%b", cyc, rdy, arvalid, exp_rdy, m_issue);
      end
      if (arvalid) begin
        ids.push_back(int'(arid));
        total++;
        if (araddr !== pd[int'(arid[1:0])*PDW +: 32] || arlen !== pd[int'(arid[1:0])*PDW+64 +: LW]) begin
          bad++;
          $display("FAIL rr_fields: id=%0d addr=%h len=%0d, required addr=%h len=%0d", arid, araddr, arlen,
                   pd[int'(arid[1:0])*PDW +: 32], pd[int'(arid[1:0])*PDW+64 +: LW]);
        end
      end
      if (rdy != 0) grants++;
      advance();
    end
    total++;
    if (ids.size() != 5 || ids[0] != 0 || ids[1] != 1 || ids[2] != 2 || ids[3] != 3 || ids[4] != 0 || grants != 5) begin
      bad++;
      $display("FAIL rr_sequence: %0d ids (%p), %0d grants, required ids 0,1,2,3,0 and 5 grants", ids.size(), ids, grants);
    end
  endtask

  task automatic test_max_outs();
    bit seen2;
    int others;
    idle_inputs(); do_reset(); rand_pd();
    vld = 4'b0100; arready = 1'b1;
    repeat (8) begin #1; model_eval(); advance(); end
    total++;
    if (m_outs[2] != 4) begin
      bad++;
      $display("FAIL max_fill: model outs2=%0d, required 4", m_outs[2]);
    end
    vld = 4'hF; others = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1; model_eval();
      total++;
      if (rdy !== exp_rdy || rdy[2] !== 1'b0) begin
        bad++;
        $display("FAIL max_block c%0d: rdy=%b, required %b with client 2 blocked", cyc, rdy, exp_rdy);
      end
      if (rdy != 0) others++;
      advance();
    end
    total++;
    if (others < 5) begin
      bad++;
      $display("FAIL max_others: %0d grants to other clients, required at least 5", others);
    end
    rid = 4'd2; rlast = 1'b1; rvalid = 1'b1; rdata = {$urandom, $urandom};
    #1; model_eval(); advance();
    rvalid = 1'b0; rlast = 1'b0; seen2 = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1; model_eval();
      total++;
      if (rdy !== exp_rdy) begin
        bad++;
        $display("FAIL max_resume c%0d: rdy=%b, required %b", cyc, rdy, exp_rdy);
      end
      if (rdy[2]) seen2 = 1;
      advance();
    end
    total++;
    if (!seen2) begin
      bad++;
      $display("FAIL max_regrant: client 2 granted=%0d, required 1", seen2);
    end
  endtask

  task automatic test_ar_stall();
    logic [31:0] a0;
    logic [LW-1:0] l0;
    idle_inputs(); do_reset(); rand_pd();
    vld = 4'b0010;
    a0 = pd[1*PDW +: 32]; l0 = pd[1*PDW+64 +: LW];
    #1; model_eval(); advance();
    for (int cyc = 0; cyc < 10; cyc++) begin
      rand_pd(); vld = 4'($urandom);
      #1;
      total++;
      if (arvalid !== 1'b1 || araddr !== a0 || arlen !== l0 || arid !== 4'd1 || rdy !== 4'b0) begin
        bad++;
        $display("FAIL stall c%0d: arvalid=%b addr=%h len=%0d id=%0d rdy=%b, required 1/%h/%0d/1/0000",
                 cyc, arvalid, araddr, arlen, arid, rdy, a0, l0);
      end
      model_eval(); advance();
    end
    vld = 4'b0; arready = 1'b1;
    #1; model_eval(); advance();
    arready = 1'b0;
    #1;
    total++;
    if (arvalid !== 1'b0) begin
      bad++;
      $display("FAIL stall_release: arvalid=%b, required 0", arvalid);
    end
  endtask

  task automatic test_r_interleave();
    int seq [3];
    seq[0] = 1; seq[1] = 3; seq[2] = 1;
    idle_inputs(); do_reset();
    resp_rdy = 4'b0111;
    for (int b = 0; b < 3; b++) begin
      rid = IDW'(seq[b]); rvalid = 1'b1; rlast = 1'($urandom_range(0, 1)) & 1'b0;
      rdata = {$urandom, $urandom};
      #1; model_eval();
      total++;
      if (resp_vld !== exp_rvld || resp_last !== exp_rlast || rready !== exp_rready || resp_pd !== rdata) begin
        bad++;
        $display("FAIL route b%0d: vld=%b last=%b rready=%b pd=%h, required %b/%b/%b/%h",
                 b, resp_vld, resp_last, rready, resp_pd, exp_rvld, exp_rlast, exp_rready, rdata);
      end
      total++;
      if (rready !== (seq[b] != 3)) begin
        bad++;
        $display("FAIL route_rready b%0d: rready=%b for rid %0d, required %0d", b, rready, seq[b], seq[b] != 3);
      end
      advance();
    end
    rvalid = 1'b0;
  endtask

  task automatic test_bad_rid();
    idle_inputs(); do_reset();
    resp_rdy = 4'b0000; rid = 4'h9; rvalid = 1'b1; rdata = {$urandom, $urandom};
    #1; model_eval();
    total++;
    if (rready !== 1'b1 || resp_vld !== 4'b0 || rd_err !== 1'b0) begin
      bad++;
      $display("FAIL bad_rid: rready=%b vld=%b err=%b, required 1/0000/0", rready, resp_vld, rd_err);
    end
    advance();
    rvalid = 1'b0; rid = '0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      #1;
      total++;
      if (rd_err !== 1'b1) begin
        bad++;
        $display("FAIL err_sticky c%0d: rd_err=%b, required 1", cyc, rd_err);
      end
      model_eval(); advance();
    end
    do_reset(); #1;
    total++;
    if (rd_err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear: rd_err=%b, required 0", rd_err);
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs(); do_reset(); rand_pd();
    vld = 4'b0001; arready = 1'b1;
    repeat (5) begin #1; model_eval(); advance(); end
    vld = 4'b0; arready = 1'b0;
    #1;
    total++;
    if (m_outs[0] != 3 || arvalid !== 1'b1 || !m_issue) begin
      bad++;
      $display("FAIL mid_setup: outs0=%0d arvalid=%b, required 3 and 1", m_outs[0], arvalid);
    end
    rst = 1'b1; model_reset();
    #1;
    total++;
    if (arvalid !== 1'b0 || rdy !== 4'b0 || arid !== '0) begin
      bad++;
      $display("FAIL mid_reset: arvalid=%b rdy=%b arid=%0d, required 0/0000/0", arvalid, rdy, arid);
    end
    @(negedge clk); rst = 1'b0;
    rid = '0; rlast = 1'b1; rvalid = 1'b1; resp_rdy = 4'hF;
    #1; model_eval(); advance();
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    total++;
    if (rd_err !== 1'b1) begin
      bad++;
      $display("FAIL stale_beat: rd_err=%b, required 1", rd_err);
    end
    vld = 4'hF;
    #1; model_eval();
    total++;
    if (rdy !== 4'b0001) begin
      bad++;
      $display("FAIL ptr_reset: rdy=%b, required 0001", rdy);
    end
    advance();
  endtask

  task automatic test_random();
    idle_inputs(); do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      rand_pd();
      vld      = 4'($urandom);
      arready  = 1'($urandom_range(0, 2) != 0);
      resp_rdy = 4'($urandom);
      rvalid   = 1'($urandom_range(0, 1));
      rlast    = 1'($urandom_range(0, 2) == 0);
      rid      = ($urandom_range(0, 19) == 0) ? IDW'($urandom_range(4, 15)) : IDW'($urandom_range(0, 3));
      rdata    = {$urandom, $urandom};
      #1; model_eval();
      total++;
      if (rdy !== exp_rdy || arvalid !== m_issue || resp_vld !== exp_rvld || resp_last !== exp_rlast ||
          rready !== exp_rready || resp_pd !== rdata || rd_err !== m_err) begin
        bad++;
        $display("FAIL rand_ctl c%0d: rdy=%b arv=%b rvld=%b rlast=%b rready=%b err=%b, required %b/%b/%b/%b/%b/%b",
                 cyc, rdy, arvalid, resp_vld, resp_last, rready, rd_err,
                 exp_rdy, m_issue, exp_rvld, exp_rlast, exp_rready, m_err);
      end
      total++;
      if (arid !== IDW'(m_arid) || araddr !== m_araddr || arlen !== m_arlen) begin
        bad++;
        $display("FAIL rand_ar c%0d: id=%0d addr=%h len=%0d, required %0d/%h/%0d",
                 cyc, arid, araddr, arlen, m_arid, m_araddr, m_arlen);
      end
      advance();
    end
  endtask

  initial begin
    rst = 1'b1; pd = '0;
    idle_inputs(); model_reset();
    test_reset();
    test_round_robin();
    test_max_outs();
    test_ar_stall();
    test_r_interleave();
    test_bad_rid();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at 200000, required finish");
    $fatal(1);
  end

endmodule

// File: doc/mcif_rd_arb_4r.md
Name: mcif_rd_arb_4r

Overview:
- Round-robin arbiter and scheduler that shares one AXI read master (AR + R channels) among four feature-read clients.
- Tags each burst with the requester index on ARID and tracks outstanding bursts per client.
- Routes returning R beats back to the owning client by RID.
- Sits between the feature-fetch engines and the AXI interconnect, alongside the write-side path.

Parameters:
M_AXI_ID_WIDTH, 4, AXI ID width (>=2)
M_AXI_DATA_WIDTH, `MAX_DAT_DW*`Tout, AXI data width
LEN_W, `log2AXI_BURST_LEN, burst length field width
MAX_OUTS, 4, max outstanding bursts per client (power of two, <=16)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rd_req_vld  in  4  per-client request valid
rd_req_rdy  out  4  per-client request accept
rd_req_pd  in  4*(LEN_W+64)  client i slice: [31:0] byte address, [63:32] reserved (ignored), [LEN_W+63:64] burst length minus one
rd_resp_vld  out  4  per-client R beat valid
rd_resp_rdy  in  4  per-client R beat ready
rd_resp_pd  out  M_AXI_DATA_WIDTH  R data, shared by all clients
rd_resp_last  out  4  per-client last beat of burst
rd_err  out  1  sticky: R beat with unknown RID seen
M_AXI_ARID/ARADDR/ARLEN/ARVALID  out  ID/32/LEN_W/1  AR channel
M_AXI_ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT/ARQOS  out  3/2/1/4/3/4  constants: clog2(DW/8), 2'b01, 0, 4'b0010, 0, 0
M_AXI_ARREADY  in  1  AR ready
M_AXI_RID/RDATA/RRESP/RLAST/RVALID  in  ID/DW/2/1/1  R channel; RRESP ignored
M_AXI_RREADY  out  1  R ready

Behaviour:
- One clock domain; all registers clear asynchronously on rst. Reset values:
  - rd_req_rdy = 0, M_AXI_ARVALID = 0, ARID/ARADDR/ARLEN = 0, rd_err = 0.
  - Round-robin pointer = 0, all outstanding counters = 0, state = IDLE.
- Eligibility: elig[i] = rd_req_vld[i] & (outs[i] < MAX_OUTS).
- State IDLE:
  - If any elig is set, grant g = first eligible index searching ptr, ptr+1, … mod 4.
  - rd_req_rdy[g] = 1 combinationally in that cycle; all other rdy bits = 0.
  - Latch ARADDR = pd[31:0], ARLEN = pd[top:64], ARID = g zero-extended.
  - ptr <= (g+1) mod 4; outs[g] increments; go to ISSUE.
  - rd_req_rdy is never asserted outside IDLE.
- State ISSUE:
  - ARVALID = 1; AR fields held stable.
  - On ARREADY, ARVALID drops next cycle and state returns to IDLE.
  - Peak rate is one AR every 2 cycles.
- R routing, combinational:
  - If RID < 4: k = RID[1:0]; rd_resp_vld[k] = RVALID; rd_resp_last[k] = RLAST; RREADY = rd_resp_rdy[k].
  - rd_resp_pd = RDATA always. Vld/last bits of non-matching clients are 0.
- Unknown RID (upper bits nonzero): RREADY = 1 (beat drained and dropped), no client valid, rd_err set until rst.
- Completion: RVALID & RREADY & RLAST with RID = k decrements outs[k].
  - Same-cycle increment and decrement on the same client leaves outs unchanged.
  - A decrement at outs = 0 is ignored and sets rd_err.
- Client flow control: a client at MAX_OUTS is skipped by arbitration; the pointer advances only on a grant.
- Interleaved R beats from different IDs are supported; no data buffering, latency 0.
- rst mid-burst: counters clear and ARVALID drops. The interconnect must also be reset; stale R beats after reset drain with rd_err set, due to the decrement-at-zero rule.

Test Plan:
- All 4 clients hold vld, ARREADY = 1 -> ARID sequence 0,1,2,3,0; one grant every 2 cycles; ARADDR/ARLEN match each client's pd.
- Client 2 issues 4 bursts with R held off (MAX_OUTS = 4) -> 5th request not granted while clients 0, 1, 3 keep being served; one RLAST with RID = 2 -> client 2 granted next in its turn.
- ARREADY held low 10 cycles in ISSUE -> ARVALID, ARADDR, ARID stable for all 10 cycles; rd_req_rdy = 0 throughout.
- R beats interleaved RID = 1, 3, 1 with rd_resp_rdy[3] = 0 -> RREADY low on the RID 3 beat; RDATA delivered only to the matching client vld.
- RID = 4'h9 beat -> RREADY = 1, no rd_resp_vld, rd_err = 1 held until rst.
- Assert rst while outs[0] = 3 and in ISSUE -> next cycle ARVALID = 0, outs all 0, ptr = 0, rd_req_rdy = 0.
